// File: rtl/screen_draw_ctrl.sv
// rtl/screen_draw_ctrl.sv - full-screen redraw sequencer for the VGA adapter
//
// Purpose: on a request, runs exactly one background drawer (game board,
// player-1 win or player-2 win) for one full frame. Its x/y is realigned
// with its later-arriving ROM colour, and the pixel stream is driven to the
// VGA adapter.
//
// Ports:
//   CLOCK_50                 system clock
//   reset                    synchronous, active-high reset
//   req                      one-cycle draw request (ignored unless idle)
//   screen_sel               0 board, 1 win p1, 2 win p2, 3 reserved (ignored)
//   bg_/w1_/w2_x, _y, _col   drawer coordinate and colour outputs
//   start_bg/_w1/_w2         drawer advance enables (at most one high)
//   vga_x/vga_y/vga_colour   pixel to the VGA adapter, held while vga_plot=0
//   vga_plot                 VGA write enable
//   busy                     high from request accept until done
//   done                     one-cycle pulse at end of frame

module screen_draw_ctrl #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int XY_LAT  = 1,
  parameter int COL_LAT = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       req,
  input  logic [1:0] screen_sel,
  input  logic [7:0] bg_x,
  input  logic [7:0] w1_x,
  input  logic [7:0] w2_x,
  input  logic [6:0] bg_y,
  input  logic [6:0] w1_y,
  input  logic [6:0] w2_y,
  input  logic [2:0] bg_col,
  input  logic [2:0] w1_col,
  input  logic [2:0] w2_col,
  output logic       start_bg,
  output logic       start_w1,
  output logic       start_w2,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam int         NPIX       = H_RES * V_RES;
  localparam logic [14:0] PIX_LAST   = 15'(NPIX - 1);
  // Flush lasts XY_LAT+COL_LAT+1 cycles so the last pixel leaves the pipe.
  localparam logic [2:0]  FLUSH_LAST = 3'(XY_LAT + COL_LAT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] SEL_BG = 2'd0;
  localparam logic [1:0] SEL_W1 = 2'd1;
  localparam logic [1:0] SEL_W2 = 2'd2;

  logic [1:0]  state;
  logic [1:0]  sel;
  logic [14:0] pix_cnt;
  logic [2:0]  flush_cnt;

  logic        start_any;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_col;

  logic [XY_LAT-1:0]  start_dly;
  logic [COL_LAT-1:0] v_pipe;
  logic [7:0]         x_pipe [COL_LAT];
  logic [6:0]         y_pipe [COL_LAT];

  // Starts are decoded straight from state so a reset drops them on the
  // very next edge without extra registers.
  assign start_bg  = (state == S_DRAW) && (sel == SEL_BG);
  assign start_w1  = (state == S_DRAW) && (sel == SEL_W1);
  assign start_w2  = (state == S_DRAW) && (sel == SEL_W2);
  assign start_any = start_bg | start_w1 | start_w2;

  always_comb begin
    sel_x   = bg_x;
    sel_y   = bg_y;
    sel_col = bg_col;
    case (sel)
      SEL_W1: begin
        sel_x   = w1_x;
        sel_y   = w1_y;
        sel_col = w1_col;
      end
      SEL_W2: begin
        sel_x   = w2_x;
        sel_y   = w2_y;
        sel_col = w2_col;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= S_IDLE;
      sel       <= SEL_BG;
      pix_cnt   <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req && (screen_sel != 2'd3)) begin
            sel     <= screen_sel;
            busy    <= 1'b1;
            pix_cnt <= '0;
            state   <= S_DRAW;
          end
        end
        S_DRAW: begin
          // Exactly NPIX start cycles wraps the drawer back to (0,0).
          if (pix_cnt == PIX_LAST) begin
            pix_cnt   <= '0;
            flush_cnt <= '0;
            state     <= S_FLUSH;
          end else begin
            pix_cnt <= pix_cnt + 15'd1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_cnt <= '0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            flush_cnt <= flush_cnt + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Valid follows start by XY_LAT, then rides with x/y for COL_LAT cycles so
  // it pops out alongside the ROM colour that belongs to those coordinates.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      start_dly <= '0;
      v_pipe    <= '0;
      for (int i = 0; i < COL_LAT; i++) begin
        x_pipe[i] <= '0;
        y_pipe[i] <= '0;
      end
    end else begin
      start_dly[0] <= start_any;
      for (int i = 1; i < XY_LAT; i++) begin
        start_dly[i] <= start_dly[i-1];
      end
      v_pipe[0] <= start_dly[XY_LAT-1];
      x_pipe[0] <= sel_x;
      y_pipe[0] <= sel_y;
      for (int i = 1; i < COL_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        x_pipe[i] <= x_pipe[i-1];
        y_pipe[i] <= y_pipe[i-1];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= v_pipe[COL_LAT-1];
      if (v_pipe[COL_LAT-1]) begin
        vga_x      <= x_pipe[COL_LAT-1];
        vga_y      <= y_pipe[COL_LAT-1];
        vga_colour <= sel_col;
      end
    end
  end

endmodule

// File: tb/tb_screen_draw_ctrl.sv
// tb/tb_screen_draw_ctrl.sv - self-checking bench for screen_draw_ctrl

module tb_screen_draw_ctrl;

  localparam int NPIX = 19200;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [1:0] screen_sel = 2'd0;

  logic       start_bg, start_w1, start_w2;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  logic [7:0] xr [3];
  logic [7:0] dx [3];
  logic [6:0] yr [3];
  logic [6:0] dy [3];
  logic [2:0] c1 [3];
  logic [2:0] dc [3];
  logic [2:0] st;
  logic [23:0] out_vec;

  assign st = {start_w2, start_w1, start_bg};
  assign out_vec = {start_w2, start_w1, start_bg, busy, done, vga_plot,
                    vga_x, vga_y, vga_colour};

  always #10 CLOCK_50 = ~CLOCK_50;

  screen_draw_ctrl dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req        (req),
    .screen_sel (screen_sel),
    .bg_x       (dx[0]),
    .w1_x       (dx[1]),
    .w2_x       (dx[2]),
    .bg_y       (dy[0]),
    .w1_y       (dy[1]),
    .w2_y       (dy[2]),
    .bg_col     (dc[0]),
    .w1_col     (dc[1]),
    .w2_col     (dc[2]),
    .start_bg   (start_bg),
    .start_w1   (start_w1),
    .start_w2   (start_w2),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .done       (done)
  );

  // Each screen has its own colour rule so a wrong mux shows up at once.
  function automatic logic [2:0] col_f(input int s, input int x, input int y);
    case (s)
      0:       return 3'((x + y) % 8);
      1:       return 3'((x + 2 * y + 1) % 8);
      default: return 3'((3 * x + y + 5) % 8);
    endcase
  endfunction

  // Drawers: registered x/y one cycle after start, ROM colour two cycles later.
  always @(posedge CLOCK_50) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        xr[i] <= 8'd0;
        yr[i] <= 7'd0;
        dx[i] <= 8'd0;
        dy[i] <= 7'd0;
      end else if (st[i]) begin
        dx[i] <= xr[i];
        dy[i] <= yr[i];
        if (xr[i] == 8'd159) begin
          xr[i] <= 8'd0;
          yr[i] <= (yr[i] == 7'd119) ? 7'd0 : yr[i] + 7'd1;
        end else begin
          xr[i] <= xr[i] + 8'd1;
        end
      end
      c1[i] <= col_f(i, int'(dx[i]), int'(dy[i]));
      dc[i] <= c1[i];
    end
  end

  int passed = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Frame statistics gathered from the DUT outputs, published on done.
  int cyc = 0;
  int done_cnt = 0;
  int fr_plots = 0, fr_bad = 0, fr_lat = 0;
  int fr_fx = 0, fr_fy = 0, fr_lx = 0, fr_ly = 0, fr_lc = 0;
  int fr_scnt [3];

  // Timeline model: cycle r of a frame (r=0 is the first start cycle) fixes
  // every output directly from the frame rules.
  initial begin
    int  r = 0;
    bit  in_frame = 0;
    int  fsel = 0;
    int  lx = 0, ly = 0, lc = 0;
    bit  acc;
    logic [2:0] es;
    logic eb, ed, ep;
    logic [23:0] exp_vec;
    bit  prev_st = 0, prev_plot = 0;
    int  start_rise = 0;
    int  m_plots = 0, m_bad = 0, m_lat = 0, m_fx = 0, m_fy = 0;
    int  m_lx = 0, m_ly = 0, m_lc = 0;
    int  scnt [3];
    bit  seen [NPIX];
    int  idx;
    forever begin
      @(posedge CLOCK_50);
      cyc++;
      if (reset) begin
        in_frame = 0;
        lx = 0; ly = 0; lc = 0;
      end else begin
        acc = !in_frame && req && (screen_sel != 2'd3);
        if (in_frame) begin
          r++;
          if (r > NPIX + 4) in_frame = 0;
        end
        if (acc) begin
          in_frame = 1;
          r = 0;
          fsel = int'(screen_sel);
        end
      end
      @(negedge CLOCK_50);
      es = 3'b000;
      if (in_frame && r < NPIX) es[fsel] = 1'b1;
      eb = in_frame && (r < NPIX + 4);
      ed = in_frame && (r == NPIX + 4);
      ep = in_frame && (r >= 4) && (r < NPIX + 4);
      if (ep) begin
        lx = (r - 4) % 160;
        ly = (r - 4) / 160;
        lc = int'(col_f(fsel, lx, ly));
      end
      exp_vec = {es, eb, ed, ep, 8'(lx), 7'(ly), 3'(lc)};
      check($sformatf("outputs_cycle%0d", cyc), out_vec, exp_vec);

      if ((st != 3'b000) && !prev_st) begin
        start_rise = cyc;
        for (int i = 0; i < 3; i++) scnt[i] = 0;
      end
      for (int i = 0; i < 3; i++) if (st[i]) scnt[i]++;
      if (vga_plot && !prev_plot) begin
        m_lat = cyc - start_rise;
        m_fx = int'(vga_x);
        m_fy = int'(vga_y);
        m_plots = 0;
        m_bad = 0;
        for (int k = 0; k < NPIX; k++) seen[k] = 0;
      end
      if (vga_plot) begin
        m_plots++;
        if (vga_x >= 8'd160 || vga_y >= 7'd120) m_bad++;
        else begin
          idx = int'(vga_y) * 160 + int'(vga_x);
          if (seen[idx]) m_bad++;
          else seen[idx] = 1;
        end
        m_lx = int'(vga_x);
        m_ly = int'(vga_y);
        m_lc = int'(vga_colour);
      end
      if (done) begin
        done_cnt++;
        fr_plots = m_plots; fr_bad = m_bad; fr_lat = m_lat;
        fr_fx = m_fx; fr_fy = m_fy;
        fr_lx = m_lx; fr_ly = m_ly; fr_lc = m_lc;
        for (int i = 0; i < 3; i++) fr_scnt[i] = scnt[i];
      end
      prev_st = (st != 3'b000);
      prev_plot = vga_plot;
    end
  end

  task automatic cycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_req(input logic [1:0] s);
    req = 1'b1;
    screen_sel = s;
    cycle();
    req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < NPIX + 100) begin
      cycle();
      n++;
    end
    check("done_arrives", done, 1);
  endtask

  task automatic check_frame(input int s, input int last_c, input int d0);
    check("frame_plots", fr_plots, NPIX);
    check("frame_dup_or_bad", fr_bad, 0);
    check("first_plot_latency", fr_lat, 4);
    check("first_x", fr_fx, 0);
    check("first_y", fr_fy, 0);
    check("last_x", fr_lx, 159);
    check("last_y", fr_ly, 119);
    check("last_colour", fr_lc, last_c);
    for (int i = 0; i < 3; i++)
      check($sformatf("start%0d_cycles", i), fr_scnt[i], (i == s) ? NPIX : 0);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    repeat (3) cycle();
    check("reset_outputs", out_vec, 0);
    reset = 1'b0;
    cycle();

    // Reserved selection is ignored.
    d0 = done_cnt;
    pulse_req(2'd3);
    repeat (8) begin
      check("sel3_idle", out_vec[23:18], 0);
      cycle();
    end
    check("sel3_no_done", done_cnt - d0, 0);

    // Player-1 screen; selection changes mid-frame have no effect.
    d0 = done_cnt;
    pulse_req(2'd1);
    screen_sel = 2'd0;
    repeat (5) cycle();
    check("w1_pixel1_x", vga_x, 1);
    check("w1_pixel1_y", vga_y, 0);
    check("w1_pixel1_colour", vga_colour, 2);
    wait_done();
    req = 1'b1;
    screen_sel = 2'd2;
    cycle();
    req = 1'b0;
    check_frame(1, 6, d0);

    // Player-2 screen right after.
    d0 = done_cnt;
    pulse_req(2'd2);
    wait_done();
    cycle();
    check_frame(2, 1, d0);

    // Player-2 screen aborted by reset while pixel 10000 (80,62) is out.
    d0 = done_cnt;
    pulse_req(2'd2);
    repeat (10004) cycle();
    check("abort_pixel", {vga_plot, vga_x, vga_y}, {1'b1, 8'd80, 7'd62});
    reset = 1'b1;
    cycle();
    check("abort_reset_outputs", out_vec, 0);
    reset = 1'b0;
    repeat (30) cycle();
    check("abort_no_done", done_cnt - d0, 0);

    // Board screen with stray requests at pixel 500 and in the done cycle.
    d0 = done_cnt;
    pulse_req(2'd0);
    repeat (504) cycle();
    req = 1'b1;
    screen_sel = 2'd1;
    cycle();
    req = 1'b0;
    screen_sel = 2'd3;
    wait_done();
    req = 1'b1;
    screen_sel = 2'd0;
    cycle();
    req = 1'b0;
    check_frame(0, 6, d0);
    repeat (20) cycle();
    check("single_frame_only", done_cnt - d0, 1);
    check("idle_after_frame", out_vec[23:18], 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
